// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg: shared BTree NoC flit layout helpers and default sizes.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_NUM_PE     = 8;

  // Flit = {dest address, payload}; the address sits directly above the payload.
  function automatic int addr_msb(input int data_width, input int addr_width);
    return data_width + addr_width - 1;
  endfunction

  function automatic int addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int data_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo: valid/ready FIFO with registered storage, no bypass.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] push_data_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  output logic [Width-1:0] pop_data_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth) + 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  assign w_full       = (count_q == CntWidth'(Depth));
  assign w_empty      = (count_q == '0);
  assign push_ready_o = !w_full;
  assign pop_valid_o  = !w_empty;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign w_push       = push_valid_i && !w_full;
  assign w_pop        = pop_ready_i && !w_empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/pe_net_if.sv
// ----------------------------------------------------------------------------
// pe_net_if: PE-side NoC endpoint with TX/RX FIFOs, address check, status.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_net_if
  import noc_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int AddrWidth = DEF_ADDR_WIDTH,
  parameter int MyAddr    = 0,
  parameter int FifoDepth = 4,
  parameter int CntWidth  = 16
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-1:0]           i_tx_data,
  input  logic [AddrWidth-1:0]           i_tx_dest,
  input  logic                           i_tx_valid,
  output logic                           o_tx_ready,
  output logic [DataWidth+AddrWidth-1:0] o_noc_data,
  output logic                           o_noc_data_valid,
  input  logic                           i_noc_data_ready,
  input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
  input  logic                           i_noc_data_valid,
  output logic                           o_noc_data_ready,
  output logic [DataWidth-1:0]           o_rx_data,
  output logic                           o_rx_valid,
  input  logic                           i_rx_ready,
  output logic [CntWidth-1:0]            o_tx_count,
  output logic [CntWidth-1:0]            o_rx_count,
  output logic                           o_err_misroute,
  output logic                           o_err_self
);

  localparam int FlitWidth = DataWidth + AddrWidth;
  localparam int AddrMsb   = addr_msb(DataWidth, AddrWidth);
  localparam int AddrLsb   = addr_lsb(DataWidth);
  localparam int DataMsb   = data_msb(DataWidth);
  localparam int DataLsb   = data_lsb();
  localparam logic [AddrWidth-1:0] OwnAddr = AddrWidth'(MyAddr);

  logic [FlitWidth-1:0] w_tx_flit;
  logic [AddrWidth-1:0] w_rx_addr;
  logic [DataWidth-1:0] w_rx_payload;
  logic                 w_tx_to_self;
  logic                 w_tx_push_valid;
  logic                 w_tx_self;
  logic                 w_noc_tx_xfer;
  logic                 w_rx_addr_ok;
  logic                 w_rx_push_valid;
  logic                 w_rx_push;
  logic                 w_rx_misroute;

  logic [CntWidth-1:0]  tx_count_q, tx_count_d;
  logic [CntWidth-1:0]  rx_count_q, rx_count_d;
  logic                 err_misroute_q, err_misroute_d;
  logic                 err_self_q, err_self_d;

  always_comb begin
    w_tx_flit                  = '0;
    w_tx_flit[AddrMsb:AddrLsb] = i_tx_dest;
    w_tx_flit[DataMsb:DataLsb] = i_tx_data;
  end

  assign w_rx_addr    = i_noc_data[AddrMsb:AddrLsb];
  assign w_rx_payload = i_noc_data[DataMsb:DataLsb];

  // Self-addressed requests still complete the PE handshake, but never reach the FIFO.
  assign w_tx_to_self    = (i_tx_dest == OwnAddr);
  assign w_tx_push_valid = i_tx_valid && !w_tx_to_self;
  assign w_tx_self       = i_tx_valid && o_tx_ready && w_tx_to_self;
  assign w_noc_tx_xfer   = o_noc_data_valid && i_noc_data_ready;

  assign w_rx_addr_ok    = (w_rx_addr == OwnAddr);
  assign w_rx_push_valid = i_noc_data_valid && w_rx_addr_ok;
  assign w_rx_push       = i_noc_data_valid && o_noc_data_ready && w_rx_addr_ok;
  assign w_rx_misroute   = i_noc_data_valid && o_noc_data_ready && !w_rx_addr_ok;

  sync_fifo #(
    .Width (FlitWidth),
    .Depth (FifoDepth)
  ) u_tx_fifo (
    .clk_i        (i_sclk),
    .rst_ni       (i_reset),
    .push_data_i  (w_tx_flit),
    .push_valid_i (w_tx_push_valid),
    .push_ready_o (o_tx_ready),
    .pop_data_o   (o_noc_data),
    .pop_valid_o  (o_noc_data_valid),
    .pop_ready_i  (i_noc_data_ready)
  );

  sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_rx_fifo (
    .clk_i        (i_sclk),
    .rst_ni       (i_reset),
    .push_data_i  (w_rx_payload),
    .push_valid_i (w_rx_push_valid),
    .push_ready_o (o_noc_data_ready),
    .pop_data_o   (o_rx_data),
    .pop_valid_o  (o_rx_valid),
    .pop_ready_i  (i_rx_ready)
  );

  always_comb begin
    tx_count_d     = tx_count_q;
    rx_count_d     = rx_count_q;
    err_misroute_d = err_misroute_q;
    err_self_d     = err_self_q;
    if (w_noc_tx_xfer) tx_count_d     = tx_count_q + CntWidth'(1);
    if (w_rx_push)     rx_count_d     = rx_count_q + CntWidth'(1);
    if (w_rx_misroute) err_misroute_d = 1'b1;
    if (w_tx_self)     err_self_d     = 1'b1;
  end

  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      err_misroute_q <= 1'b0;
      err_self_q     <= 1'b0;
    end else begin
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      err_misroute_q <= err_misroute_d;
      err_self_q     <= err_self_d;
    end
  end

  assign o_tx_count     = tx_count_q;
  assign o_rx_count     = rx_count_q;
  assign o_err_misroute = err_misroute_q;
  assign o_err_self     = err_self_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_net_if.sv
// ----------------------------------------------------------------------------
// tb_pe_net_if: directed + random stimulus against a queue-based endpoint model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pe_net_if;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int FW    = DW + AW;
  localparam int MY    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] i_tx_data;
  logic [AW-1:0] i_tx_dest;
  logic          i_tx_valid;
  logic          o_tx_ready;
  logic [FW-1:0] o_noc_data;
  logic          o_noc_data_valid;
  logic          i_noc_data_ready;
  logic [FW-1:0] i_noc_data;
  logic          i_noc_data_valid;
  logic          o_noc_data_ready;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid;
  logic          i_rx_ready;
  logic [CW-1:0] o_tx_count;
  logic [CW-1:0] o_rx_count;
  logic          o_err_misroute;
  logic          o_err_self;

  always #5 clk = ~clk;

  pe_net_if #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .MyAddr    (MY),
    .FifoDepth (DEPTH),
    .CntWidth  (CW)
  ) dut (
    .i_sclk           (clk),
    .i_reset          (rst_n),
    .i_tx_data        (i_tx_data),
    .i_tx_dest        (i_tx_dest),
    .i_tx_valid       (i_tx_valid),
    .o_tx_ready       (o_tx_ready),
    .o_noc_data       (o_noc_data),
    .o_noc_data_valid (o_noc_data_valid),
    .i_noc_data_ready (i_noc_data_ready),
    .i_noc_data       (i_noc_data),
    .i_noc_data_valid (i_noc_data_valid),
    .o_noc_data_ready (o_noc_data_ready),
    .o_rx_data        (o_rx_data),
    .o_rx_valid       (o_rx_valid),
    .i_rx_ready       (i_rx_ready),
    .o_tx_count       (o_tx_count),
    .o_rx_count       (o_rx_count),
    .o_err_misroute   (o_err_misroute),
    .o_err_self       (o_err_self)
  );

  // Reference model: FIFO contents as queues, counters and sticky flags as plain variables.
  logic [FW-1:0] m_txq[$];
  logic [DW-1:0] m_rxq[$];
  logic [CW-1:0] m_txc;
  logic [CW-1:0] m_rxc;
  logic          m_emis;
  logic          m_eself;
  bit            last_tx_acc;
  bit            last_nin_acc;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_txq.delete();
    m_rxq.delete();
    m_txc   = '0;
    m_rxc   = '0;
    m_emis  = 1'b0;
    m_eself = 1'b0;
  endtask

  task automatic model_edge();
    bit tx_acc, noc_x, nin_acc, rx_x;
    if (!rst_n) begin
      model_clear();
      last_tx_acc  = 1'b0;
      last_nin_acc = 1'b0;
      return;
    end
    tx_acc  = i_tx_valid && (m_txq.size() < DEPTH);
    noc_x   = (m_txq.size() > 0) && i_noc_data_ready;
    nin_acc = i_noc_data_valid && (m_rxq.size() < DEPTH);
    rx_x    = (m_rxq.size() > 0) && i_rx_ready;
    if (noc_x) begin
      void'(m_txq.pop_front());
      m_txc = m_txc + 1'b1;
    end
    if (tx_acc) begin
      if (i_tx_dest == AW'(MY)) m_eself = 1'b1;
      else m_txq.push_back({i_tx_dest, i_tx_data});
    end
    if (rx_x) void'(m_rxq.pop_front());
    if (nin_acc) begin
      if (i_noc_data[FW-1:DW] == AW'(MY)) begin
        m_rxq.push_back(i_noc_data[DW-1:0]);
        m_rxc = m_rxc + 1'b1;
      end else begin
        m_emis = 1'b1;
      end
    end
    last_tx_acc  = tx_acc;
    last_nin_acc = nin_acc;
  endtask

  task automatic check_all();
    chk("tx_ready", o_tx_ready, m_txq.size() < DEPTH);
    chk("noc_valid", o_noc_data_valid, m_txq.size() != 0);
    if (m_txq.size() != 0) chk("noc_data", o_noc_data, m_txq[0]);
    chk("noc_ready", o_noc_data_ready, m_rxq.size() < DEPTH);
    chk("rx_valid", o_rx_valid, m_rxq.size() != 0);
    if (m_rxq.size() != 0) chk("rx_data", o_rx_data, m_rxq[0]);
    chk("tx_count", o_tx_count, m_txc);
    chk("rx_count", o_rx_count, m_rxc);
    chk("err_misroute", o_err_misroute, m_emis);
    chk("err_self", o_err_self, m_eself);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    i_tx_valid       = 1'b0;
    i_tx_data        = '0;
    i_tx_dest        = '0;
    i_noc_data_valid = 1'b0;
    i_noc_data       = '0;
    i_noc_data_ready = 1'b0;
    i_rx_ready       = 1'b0;
  endtask

  task automatic rand_inputs();
    i_tx_valid       = 1'($urandom_range(0, 1));
    i_tx_data        = $urandom;
    i_tx_dest        = AW'($urandom_range(0, 7));
    i_noc_data_valid = 1'($urandom_range(0, 1));
    i_noc_data       = {AW'($urandom_range(0, 7)), 32'($urandom)};
    i_noc_data_ready = 1'($urandom_range(0, 1));
    i_rx_ready       = 1'($urandom_range(0, 1));
  endtask

  initial begin
    model_clear();
    rst_n = 1'b1;
    rand_inputs();
    #1 rst_n = 1'b0;

    // Reset held for three cycles with random inputs.
    phase = "reset";
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle();
    end
    chk("rst_tx_ready", o_tx_ready, 1'b1);
    chk("rst_noc_ready", o_noc_data_ready, 1'b1);
    chk("rst_noc_valid", o_noc_data_valid, 1'b0);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_counts", {o_tx_count, o_rx_count}, 32'd0);
    chk("rst_errs", {o_err_misroute, o_err_self}, 2'b00);
    idle_inputs();
    rst_n = 1'b1;
    cycle();

    // Single send to PE 5.
    phase            = "single";
    i_noc_data_ready = 1'b1;
    i_tx_valid       = 1'b1;
    i_tx_dest        = 3'd5;
    i_tx_data        = 32'hDEADBEEF;
    cycle();
    chk("single_valid", o_noc_data_valid, 1'b1);
    chk("single_flit", o_noc_data, {3'd5, 32'hDEADBEEF});
    i_tx_valid = 1'b0;
    cycle();
    chk("single_valid_gone", o_noc_data_valid, 1'b0);
    chk("single_count", o_tx_count, 16'd1);

    // Backpressure: four flits fill the TX FIFO, the fifth waits.
    phase            = "backpressure";
    i_noc_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_tx_valid = 1'b1;
      i_tx_dest  = AW'(3 + (i % 4));
      i_tx_data  = 32'h100 + 32'(i);
      if (i_tx_dest == AW'(MY)) i_tx_dest = 3'd7;
      cycle();
    end
    chk("bp_full", o_tx_ready, 1'b0);
    i_tx_dest = 3'd4;
    i_tx_data = 32'h55;
    cycle();
    chk("bp_still_full", o_tx_ready, 1'b0);
    i_noc_data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_tx_acc) i_tx_valid = 1'b0;
    end
    chk("bp_count", o_tx_count, 16'd6);
    chk("bp_drained", o_noc_data_valid, 1'b0);

    // Receive one good flit and one misrouted flit.
    phase            = "rx_misroute";
    i_rx_ready       = 1'b0;
    i_noc_data_valid = 1'b1;
    i_noc_data       = {3'd2, 32'h1234};
    cycle();
    i_noc_data = {3'd6, 32'h5678};
    cycle();
    i_noc_data_valid = 1'b0;
    cycle();
    chk("rx_data_good", o_rx_data, 32'h1234);
    chk("rx_count_one", o_rx_count, 16'd1);
    chk("rx_misroute_set", o_err_misroute, 1'b1);
    i_rx_ready = 1'b1;
    cycle();
    chk("rx_only_one", o_rx_valid, 1'b0);

    // Self-send is consumed without reaching the NoC.
    phase      = "self";
    i_tx_valid = 1'b1;
    i_tx_dest  = AW'(MY);
    i_tx_data  = 32'hC0FFEE;
    cycle();
    chk("self_accepted", last_tx_acc, 1'b1);
    i_tx_valid = 1'b0;
    cycle();
    chk("self_err", o_err_self, 1'b1);
    chk("self_no_flit", o_noc_data_valid, 1'b0);
    chk("self_count_same", o_tx_count, 16'd6);

    // Random traffic, honouring the hold-until-accepted rule on both input sides.
    phase            = "random";
    i_tx_valid       = 1'b0;
    i_noc_data_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!i_tx_valid || last_tx_acc) begin
        i_tx_valid = 1'($urandom_range(0, 1));
        i_tx_dest  = AW'($urandom_range(0, 7));
        i_tx_data  = $urandom;
      end
      if (!i_noc_data_valid || last_nin_acc) begin
        i_noc_data_valid = 1'($urandom_range(0, 1));
        i_noc_data[DW-1:0] = $urandom;
        i_noc_data[FW-1:DW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : AW'(MY);
      end
      i_noc_data_ready = 1'($urandom_range(0, 3) != 0);
      i_rx_ready       = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_inputs();
    i_noc_data_ready = 1'b1;
    i_rx_ready       = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // RX full: a pop in the full cycle frees space only for the next cycle.
    phase            = "rx_full";
    i_rx_ready       = 1'b0;
    i_noc_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_noc_data = {3'd2, 32'hA0 + 32'(i)};
      cycle();
    end
    chk("full_not_ready", o_noc_data_ready, 1'b0);
    i_noc_data = {3'd2, 32'hB0};
    i_rx_ready = 1'b1;
    cycle();
    chk("full_pop_head", o_rx_data, 32'hA1);
    chk("full_ready_back", o_noc_data_ready, 1'b1);
    i_rx_ready = 1'b0;
    cycle();
    chk("full_pushed", last_nin_acc, 1'b1);
    i_noc_data_valid = 1'b0;
    i_noc_data_ready = 1'b0;
    i_tx_valid       = 1'b1;
    i_tx_dest        = 3'd1;
    i_tx_data        = 32'h77;
    cycle();
    i_tx_valid = 1'b0;
    cycle();

    // Asynchronous reset mid-stream drops both valids without a clock edge.
    phase = "mid_reset";
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_noc_valid", o_noc_data_valid, 1'b0);
    chk("mid_rx_valid", o_rx_valid, 1'b0);
    chk("mid_tx_ready", o_tx_ready, 1'b1);
    chk("mid_counts", {o_tx_count, o_rx_count}, 32'd0);
    chk("mid_errs", {o_err_misroute, o_err_self}, 2'b00);
    cycle();
    rst_n = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_net_if.md
Name: pe_net_if

Overview:
- PE-side network interface: the endpoint one PE uses to talk to one leaf port of the BTree NoC.
- TX path: packs PE payload plus destination address into a flit and drives it into the NoC port with a valid/ready handshake.
- RX path: accepts flits from the NoC port, checks the destination address against its own, and buffers the payload for the PE.
- One instance per PE (0..numPE-1).

Parameters:
- DataWidth, 32, payload bits per flit
- AddrWidth, 3, destination address bits; flit width = DataWidth+AddrWidth
- MyAddr, 0, this PE's address
- FifoDepth, 4, entries per TX/RX FIFO; power of 2, >=2
- CntWidth, 16, width of status counters

Ports:
- i_sclk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- i_tx_data  in  DataWidth  PE payload to send
- i_tx_dest  in  AddrWidth  destination PE address
- i_tx_valid  in  1  PE send request
- o_tx_ready  out  1  TX FIFO can accept
- o_noc_data  out  DataWidth+AddrWidth  flit to NoC (i_pe_dataN side)
- o_noc_data_valid  out  1  flit valid to NoC
- i_noc_data_ready  in  1  NoC accepts flit
- i_noc_data  in  DataWidth+AddrWidth  flit from NoC (o_pe_dataN side)
- i_noc_data_valid  in  1  NoC flit valid
- o_noc_data_ready  out  1  interface accepts NoC flit
- o_rx_data  out  DataWidth  received payload to PE
- o_rx_valid  out  1  payload available
- i_rx_ready  in  1  PE consumes payload
- o_tx_count  out  CntWidth  flits delivered to NoC
- o_rx_count  out  CntWidth  flits accepted into RX FIFO
- o_err_misroute  out  1  sticky: flit received with dest != MyAddr
- o_err_self  out  1  sticky: PE sent to MyAddr

Behaviour:
- Flit format: [DataWidth+AddrWidth-1:DataWidth] = destination address; [DataWidth-1:0] = payload.
- Reset: i_reset low clears FIFO pointers and occupancy, counters and sticky errors, immediately and asynchronously.
  - During and after reset: o_tx_ready=1, o_noc_data_ready=1, o_noc_data_valid=0, o_rx_valid=0, counts 0, errors 0.
  - o_noc_data and o_rx_data are don't-care while their valid is low.
  - Flits held in FIFOs at reset are lost; a mid-transfer reset drops valid without completing the handshake.
- Handshake (both sides): transfer occurs on a rising edge with valid&&ready.
  - valid, once raised, holds with stable data until the transfer.
  - ready never depends combinationally on valid.
- TX path:
  - o_tx_ready = TX FIFO not full.
  - An accepted request with i_tx_dest != MyAddr pushes {i_tx_dest, i_tx_data}.
  - An accepted request with i_tx_dest == MyAddr is consumed and discarded: no push, o_err_self set.
  - o_noc_data_valid = TX FIFO not empty; o_noc_data = head entry.
  - Latency: a flit accepted at edge N is presented from edge N onward (valid in cycle N+1 if the FIFO was empty).
  - Each NoC transfer pops the FIFO and increments o_tx_count.
- RX path:
  - o_noc_data_ready = RX FIFO not full.
  - An accepted flit with address == MyAddr pushes its payload and increments o_rx_count.
  - An accepted flit with address != MyAddr is discarded and sets o_err_misroute.
  - o_rx_valid = RX FIFO not empty; o_rx_data = head entry; same one-cycle latency as TX.
- FIFO rules:
  - Simultaneous push and pop is allowed whenever ready is asserted; occupancy is unchanged.
  - Full: ready low, so no push; a pop in that cycle raises ready the next cycle. There is no same-cycle bypass.
  - Empty: valid low; a pop is impossible.
  - Pointers wrap modulo FifoDepth. Occupancy is log2(FifoDepth)+1 bits.
- Counters wrap modulo 2^CntWidth. Sticky errors clear only on reset.

Decomposition:
- Shared package noc_pkg:
  - flit field positions (ADDR_MSB/LSB, DATA_MSB/LSB) as functions of DataWidth/AddrWidth
  - default DataWidth/AddrWidth/numPE constants
- One sub-module, sync_fifo (params Width, Depth; push/pop valid-ready, registered storage, full/empty).
  - Instantiated twice: TX at DataWidth+AddrWidth, RX at DataWidth.
- Address check, error flags and counters live in pe_net_if.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with random inputs -> o_tx_ready=1, o_noc_data_ready=1, both valids 0, counts 0, errors 0.
- Single send, MyAddr=0: i_tx_dest=5, i_tx_data=32'hDEADBEEF, i_noc_data_ready=1 -> next cycle o_noc_data={3'd5,32'hDEADBEEF} valid for one cycle; o_tx_count=1.
- Backpressure: i_noc_data_ready=0, offer 5 flits -> 4 accepted, o_tx_ready=0 on the 5th; release ready -> 4 flits out in order, o_tx_count=4; 5th then accepted.
- Receive/misroute, MyAddr=2: inject {3'd2,32'h1234} then {3'd6,32'h5678} -> only 32'h1234 on o_rx_data; o_rx_count=1; o_err_misroute=1.
- Self-send: i_tx_dest=MyAddr -> handshake completes, no NoC flit, o_err_self=1, o_tx_count unchanged.
- RX full with simultaneous pop and push: fill to 4, i_rx_ready=1 while NoC flit offered -> pop occurs, push held until next cycle, order preserved; assert i_reset=0 mid-stream -> valids drop immediately.
